// File: rtl/mem_arbiter.sv
// Two-channel (fetch / load-store) arbiter onto one single-port memory, with a 255-cycle watchdog.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests; default is fixed data priority.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InstrReq,
  input  logic [ADDR_W-1:0] InstrAddr,
  output logic [DATA_W-1:0] InstrRData,
  output logic              InstrValid,
  output logic              InstrErr,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWData,
  input  logic [2:0]        DataMemoryOp,
  output logic [DATA_W-1:0] DataRData,
  output logic              DataValid,
  output logic              DataErr,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic [2:0]        MemOp,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady,
  output logic              StallF,
  output logic              StallM
);

  typedef enum logic [1:0] {IDLE = 2'd0, INSTR = 2'd1, DATA = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic              grant_data;
  logic              busy;
  logic              done;

`ifdef MEM_ARBITER_RR_EN
  // Last-grant flag: 1 = data channel was granted last, 0 = fetch.
  logic last_data_q, last_data_d;
  assign grant_data = DataReq & (~InstrReq | ~last_data_q);
`else
  assign grant_data = DataReq;
`endif

  assign busy = (state_q == INSTR) || (state_q == DATA);
  // An access ends on MemReady, or on watchdog expiry when MemReady never came.
  assign done = busy && (MemReady || (cnt_q == 8'hFF));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    op_d    = op_q;
`ifdef MEM_ARBITER_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (DataReq || InstrReq) begin
          cnt_d = '0;
          if (grant_data) begin
            state_d = DATA;
            addr_d  = DataAddr;
            we_d    = DataWe;
            wdata_d = DataWData;
            op_d    = DataMemoryOp;
          end else begin
            state_d = INSTR;
            addr_d  = InstrAddr;
            we_d    = 1'b0;
            wdata_d = '0;
            op_d    = 3'b010;
          end
`ifdef MEM_ARBITER_RR_EN
          last_data_d = grant_data;
`endif
        end
      end
      INSTR, DATA: begin
        if (done) state_d = IDLE;
        else      cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      op_q    <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign MemReq   = busy;
  assign MemWe    = busy & we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemOp    = op_q;

  assign InstrValid = done && (state_q == INSTR);
  assign DataValid  = done && (state_q == DATA);
  assign InstrErr   = InstrValid & ~MemReady;
  assign DataErr    = DataValid & ~MemReady;
  // Read data is only forwarded on a real completion; a timeout returns zero.
  assign InstrRData = (InstrValid && MemReady) ? MemRData : '0;
  assign DataRData  = (DataValid && MemReady) ? MemRData : '0;

  assign StallF = InstrReq & ~InstrValid;
  assign StallM = DataReq & ~DataValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, directed scenarios, random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InstrReq, DataReq, DataWe, MemReady;
  logic [31:0] InstrAddr, DataAddr, DataWData, MemRData;
  logic [2:0]  DataMemoryOp;
  logic [31:0] InstrRData, DataRData, MemAddr, MemWData;
  logic        InstrValid, InstrErr, DataValid, DataErr, MemReq, MemWe, StallF, StallM;
  logic [2:0]  MemOp;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrRData(InstrRData),
    .InstrValid(InstrValid), .InstrErr(InstrErr),
    .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWData(DataWData),
    .DataMemoryOp(DataMemoryOp), .DataRData(DataRData), .DataValid(DataValid), .DataErr(DataErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemOp(MemOp),
    .MemRData(MemRData), .MemReady(MemReady), .StallF(StallF), .StallM(StallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding access described by its channel, captured request and cycles waited.
  logic        m_busy = 1'b0;
  logic        m_ch_data = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [2:0]  m_op = '0;
  int          m_wait = 0;
  logic        m_last_data = 1'b0;

  always @(negedge clk) begin : model
    logic busy_now, done, e_iv, e_dv, pick_data;
    busy_now = rst_n ? m_busy : 1'b0;
    done = busy_now && (MemReady || m_wait == 255);
    e_iv = done && !m_ch_data;
    e_dv = done && m_ch_data;
    chk("m_MemReq", MemReq, busy_now);
    chk("m_MemWe", MemWe, busy_now && m_we);
    chk("m_InstrValid", InstrValid, e_iv);
    chk("m_DataValid", DataValid, e_dv);
    chk("m_InstrErr", InstrErr, e_iv && !MemReady);
    chk("m_DataErr", DataErr, e_dv && !MemReady);
    chk("m_StallF", StallF, InstrReq && !e_iv);
    chk("m_StallM", StallM, DataReq && !e_dv);
    if (busy_now) begin
      chk("m_MemAddr", MemAddr, m_addr);
      chk("m_MemOp", {29'd0, MemOp}, {29'd0, m_op});
      if (m_ch_data) chk("m_MemWData", MemWData, m_wdata);
    end
    if (e_iv) chk("m_InstrRData", InstrRData, MemReady ? MemRData : 32'd0);
    if (e_dv) chk("m_DataRData", DataRData, MemReady ? MemRData : 32'd0);

    if (!rst_n) begin
      m_busy <= 1'b0;
      m_wait <= 0;
      m_last_data <= 1'b0;
    end else if (busy_now) begin
      if (done) m_busy <= 1'b0;
      else      m_wait <= m_wait + 1;
    end else if (InstrReq || DataReq) begin
      pick_data = DataReq;
`ifdef MEM_ARBITER_RR_EN
      if (DataReq && InstrReq) pick_data = !m_last_data;
`endif
      m_busy      <= 1'b1;
      m_wait      <= 0;
      m_ch_data   <= pick_data;
      m_last_data <= pick_data;
      m_addr      <= pick_data ? DataAddr : InstrAddr;
      m_we        <= pick_data ? DataWe : 1'b0;
      m_wdata     <= DataWData;
      m_op        <= pick_data ? DataMemoryOp : 3'b010;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    InstrReq = 1'b0; DataReq = 1'b0; DataWe = 1'b0; MemReady = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    InstrReq = 1'b1; InstrAddr = 32'h0; DataReq = 1'b0; DataWe = 1'b0;
    DataAddr = 32'h0; DataWData = 32'h0; DataMemoryOp = 3'b000;
    MemReady = 1'b1; MemRData = 32'h1234_5678;

    @(negedge clk);
    chk("rst_MemReq", MemReq, 0);
    chk("rst_InstrValid", InstrValid, 0);
    chk("rst_StallF", StallF, 1);
    step();
    rst_n = 1'b1;
    idle_all();
    step();

    // Single fetch, ready on first INSTR cycle
    InstrReq = 1'b1; InstrAddr = 32'h100; MemReady = 1'b1; MemRData = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("f1_StallF", StallF, 1);
    chk("f1_MemReq", MemReq, 0);
    step();
    @(negedge clk);
    chk("f2_MemAddr", MemAddr, 32'h100);
    chk("f2_MemOp", {29'd0, MemOp}, 32'd2);
    chk("f2_InstrValid", InstrValid, 1);
    chk("f2_InstrRData", InstrRData, 32'hDEAD_BEEF);
    chk("f2_StallF", StallF, 0);
    step();
    idle_all();
    @(negedge clk);
    chk("f3_StallF", StallF, 0);
    chk("f3_MemReq", MemReq, 0);
    step();

    // Simultaneous requests: data wins first (last grant was fetch), fetch follows after IDLE
    InstrReq = 1'b1; InstrAddr = 32'h300; DataReq = 1'b1; DataAddr = 32'h2000;
    DataMemoryOp = 3'b001; MemReady = 1'b1; MemRData = 32'h0BAD_F00D;
    step();
    @(negedge clk);
    chk("arb_DataValid", DataValid, 1);
    chk("arb_MemAddr_d", MemAddr, 32'h2000);
    chk("arb_InstrValid0", InstrValid, 0);
    chk("arb_StallF", StallF, 1);
    step();
`ifndef MEM_ARBITER_RR_EN
    DataReq = 1'b0;
`endif
    @(negedge clk);
    chk("arb_idle_MemReq", MemReq, 0);
    step();
    DataReq = 1'b0;
    @(negedge clk);
    chk("arb_InstrValid", InstrValid, 1);
    chk("arb_MemAddr_i", MemAddr, 32'h300);
    step();
    idle_all();
    step();

    // Write with MemReady delayed 5 cycles; requester drops DataReq mid-access
    DataReq = 1'b1; DataWe = 1'b1; DataAddr = 32'h2004; DataWData = 32'h55;
    DataMemoryOp = 3'b010; MemReady = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        DataReq = 1'b0; DataWData = 32'hFFFF_FFFF; DataAddr = 32'h0;
      end
      MemReady = (k == 6);
      @(negedge clk);
      chk("wr_MemWe", MemWe, 1);
      chk("wr_MemWData", MemWData, 32'h55);
      chk("wr_MemAddr", MemAddr, 32'h2004);
      chk("wr_DataValid", DataValid, (k == 6));
    end
    step();
    idle_all();
    step();

    // Watchdog: first pass times out, second pass has MemReady exactly at count 255
    for (int pass = 0; pass < 2; pass++) begin
      DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h4000; MemReady = 1'b0;
      MemRData = 32'hAAAA_5555;
      for (int k = 1; k <= 256; k++) begin
        step();
        if (k == 1) DataReq = 1'b0;
        if (pass == 1 && k == 256) MemReady = 1'b1;
        @(negedge clk);
        if (k == 255) chk("wd_early_DataValid", DataValid, 0);
        if (k == 256) begin
          chk("wd_DataValid", DataValid, 1);
          chk("wd_DataErr", DataErr, (pass == 0));
          chk("wd_DataRData", DataRData, (pass == 0) ? 32'd0 : 32'hAAAA_5555);
        end
      end
      step();
      idle_all();
      @(negedge clk);
      chk("wd_after_MemReq", MemReq, 0);
      step();
    end

    // Reset on 3rd DATA cycle abandons the access
    DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h2800; MemReady = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("rst_mid_MemReq", MemReq, 0);
    @(negedge clk);
    chk("rst_mid_DataValid", DataValid, 0);
    step();
    rst_n = 1'b1; MemReady = 1'b0; DataAddr = 32'h3000;
    step();
    MemReady = 1'b1;
    @(negedge clk);
    chk("rst_post_MemReq", MemReq, 1);
    chk("rst_post_MemAddr", MemAddr, 32'h3000);
    chk("rst_post_DataValid", DataValid, 1);
    step();
    idle_all();
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n        = ($urandom % 400) != 0;
      InstrReq     = $urandom % 2;
      DataReq      = $urandom % 2;
      DataWe       = $urandom % 2;
      InstrAddr    = $urandom;
      DataAddr     = $urandom;
      DataWData    = $urandom;
      DataMemoryOp = 3'($urandom % 8);
      MemReady     = ($urandom % 3) == 0;
      MemRData     = $urandom;
    end
    step();
    rst_n = 1'b1;
    idle_all();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports InstrReq (in, 1) and InstrAddr (in, 32) as the fetch request channel.
REQ-004 SHALL have ports InstrRData (out, 32) and InstrValid (out, 1) as the fetch response channel.
REQ-005 SHALL have ports DataReq (in, 1), DataWe (in, 1), DataAddr (in, 32), DataWData (in, 32) and DataMemoryOp (in, 3) as the load/store request channel, with DataMemoryOp encoded as the decode-stage MemoryOp.
REQ-006 SHALL have ports DataRData (out, 32), DataValid (out, 1) and DataErr (out, 1) as the load/store response channel.
REQ-007 SHALL have ports MemReq (out, 1), MemWe (out, 1), MemAddr (out, 32), MemWData (out, 32), MemOp (out, 3), MemRData (in, 32) and MemReady (in, 1) as the shared single-port memory.
REQ-008 SHALL have ports StallF (out, 1) and StallM (out, 1) as pipeline stall requests.
REQ-009 SHALL have output InstrErr (out, 1) to flag a timed-out fetch.

Function
REQ-010 SHALL implement FSM states IDLE, INSTR, DATA.
REQ-011 In IDLE, SHALL move on the next edge to DATA if DataReq=1, else to INSTR if InstrReq=1, else remain in IDLE (fixed data priority).
REQ-012 On leaving IDLE, SHALL latch address, we, wdata and op of the granted channel; for an INSTR grant, SHALL latch MemWe=0 and MemOp=3'b010.
REQ-013 SHALL hold MemReq=1 and drive the latched values on the Mem* outputs while in INSTR or DATA; in IDLE, SHALL drive MemReq=0.
REQ-014 SHALL pulse InstrValid (INSTR) or DataValid (DATA) combinationally in the cycle MemReady=1, pass MemRData through to the matching RData port, and return to IDLE on the next edge.
REQ-015 Minimum access latency SHALL be 2 cycles (request seen in IDLE, then MemReady on the first state cycle); back-to-back accesses always pass through IDLE.
REQ-016 SHALL drive StallF = InstrReq & ~InstrValid and StallM = DataReq & ~DataValid, combinationally.
REQ-017 SHALL run an 8-bit watchdog counter, cleared on entry to INSTR/DATA and incremented on every cycle in INSTR/DATA with MemReady=0.
REQ-018 When the counter reaches 255, SHALL pulse the matching Valid together with the matching Err for one cycle, drive RData=0 and return to IDLE.
REQ-019 If MemReady=1 and the count is 255 in the same cycle, SHALL give MemReady priority: no Err.
REQ-020 A requester dropping Req mid-access SHALL NOT abort the access; the access completes and the Valid pulse is still produced.
REQ-021 MemReady seen in IDLE SHALL be ignored.
REQ-022 Requests arriving while another access is in flight SHALL wait and be arbitrated in the next IDLE cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, counter 0, all latched fields 0, and last-grant to INSTR.
REQ-024 During reset, SHALL drive MemReq, MemWe, InstrValid, DataValid, InstrErr and DataErr to 0, and StallF/StallM per REQ-016.
REQ-025 Reset asserted mid-access SHALL abandon the access with no Valid pulse; after release, arbitration restarts from IDLE.

Configuration
REQ-026 Macro MEM_ARBITER_RR_EN defined: in IDLE with both requests high, SHALL grant the channel not granted last (round-robin), using a last-grant flag updated on each grant.
REQ-027 MEM_ARBITER_RR_EN undefined: SHALL use the fixed data priority of REQ-011, and the last-grant flag SHALL be absent.

Verification
REQ-028 InstrReq=1, InstrAddr=0x100, MemReady high on the first INSTR cycle, MemRData=0xDEADBEEF -> MemAddr=0x100 and MemOp=3'b010; InstrValid and InstrRData=0xDEADBEEF in cycle 2; StallF=1 in cycle 1 only.
REQ-029 DataReq and InstrReq both high in the same cycle, RR undefined -> DATA is granted first and INSTR is granted after the IDLE cycle; with RR defined and last grant DATA -> INSTR is granted first.
REQ-030 DataReq=1, DataWe=1, DataAddr=0x2004, DataWData=0x55, MemReady delayed 5 cycles -> MemWe=1, MemWData=0x55 stable throughout, DataValid pulses on the 6th DATA cycle.
REQ-031 MemReady never asserted -> DataValid=1 and DataErr=1 at watchdog count 255, DataRData=0, then IDLE; MemReady asserted at count 255 -> no Err.
REQ-032 rst_n pulled low on the 3rd cycle of a DATA access -> MemReq=0 immediately, no DataValid, and a new access is granted correctly after release.
